// File: rtl/ahb_apb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge slave port among several AHB-lite masters.
// Optional macro ARB_LOCK_EN: an owner asserting M_HLOCK is exempt from quota-expiry handover.
module ahb_apb_master_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned HOLD_MAX    = 4,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 32,
  localparam int unsigned IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          HCLK,
  input  logic                          RESET,
  input  logic [NUM_MASTERS-1:0]        M_HBUSREQ,
  input  logic [NUM_MASTERS-1:0]        M_HLOCK,
  input  logic [NUM_MASTERS-1:0]        M_HSEL,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_HADDR,
  input  logic [NUM_MASTERS-1:0]        M_HWRITE,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_HWDATA,
  output logic [NUM_MASTERS-1:0]        M_HGRANT,
  output logic                          M_HREADY,
  output logic [DATA_W-1:0]             M_HRDATA,
  output logic [IDX_W-1:0]              HMASTER,
  output logic                          HSEL,
  output logic [ADDR_W-1:0]             HADDR,
  output logic                          HWRITE,
  output logic [DATA_W-1:0]             HWDATA,
  output logic                          HREADY,
  input  logic                          HREADYOUT,
  input  logic [DATA_W-1:0]             HRDATA
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;
  localparam logic [3:0] Q_MAX   = 4'(HOLD_MAX);

  logic [0:0]             state, state_n;
  logic [IDX_W-1:0]       g, g_n, p, p_n, d, d_n;
  logic [3:0]             q, q_n, q_inc;
  logic                   v, v_n;
  logic [NUM_MASTERS-1:0] grant, grant_n;
  logic [IDX_W-1:0]       g_inc;
  logic [IDX_W:0]         pick_p, pick_g;
  logic                   accepted, others, lock_hold, rearb;
  logic                   unused_ok;

  // First requester at or above ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] pick(input logic [NUM_MASTERS-1:0] req,
                                          input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int unsigned    k;
    res = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      k = (32'(ptr) + 32'(i)) % NUM_MASTERS;
      if (req[IDX_W'(k)]) res = {1'b1, IDX_W'(k)};
    end
    return res;
  endfunction

  assign g_inc     = (g == IDX_W'(NUM_MASTERS - 1)) ? '0 : g + IDX_W'(1);
  assign pick_p    = pick(M_HBUSREQ, p);
  assign pick_g    = pick(M_HBUSREQ, g_inc);
  assign accepted  = M_HSEL[g];
  assign q_inc     = (accepted && (q != Q_MAX)) ? q + 4'd1 : q;
  assign others    = |(M_HBUSREQ & ~(NUM_MASTERS'(1) << g));
`ifdef ARB_LOCK_EN
  assign lock_hold = M_HLOCK[g];
`else
  assign lock_hold = 1'b0;
`endif
  assign rearb     = !M_HBUSREQ[g] || ((q_inc == Q_MAX) && others && !lock_hold);

  // Next-state logic; every arbitration event is gated by bridge ready.
  always_comb begin
    state_n = state;
    g_n     = g;
    p_n     = p;
    q_n     = q;
    d_n     = d;
    v_n     = v;
    grant_n = grant;
    if (HREADYOUT) begin
      d_n = g;
      v_n = HSEL;
      case (state)
        ST_IDLE: begin
          if (pick_p[IDX_W]) begin
            state_n = ST_OWN;
            g_n     = pick_p[IDX_W-1:0];
            q_n     = '0;
            grant_n = NUM_MASTERS'(1) << pick_p[IDX_W-1:0];
          end
        end
        ST_OWN: begin
          q_n = q_inc;
          if (rearb) begin
            p_n = g_inc;
            q_n = '0;
            if (pick_g[IDX_W]) begin
              g_n     = pick_g[IDX_W-1:0];
              grant_n = NUM_MASTERS'(1) << pick_g[IDX_W-1:0];
            end else begin
              state_n = ST_IDLE;
              grant_n = '0;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          grant_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      g     <= '0;
      p     <= '0;
      q     <= '0;
      d     <= '0;
      v     <= 1'b0;
      grant <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      p     <= p_n;
      q     <= q_n;
      d     <= d_n;
      v     <= v_n;
      grant <= grant_n;
    end
  end

  // Address phase follows the live grant; write data follows the registered data-phase owner.
  assign HSEL     = (state == ST_OWN) && M_HSEL[g];
  assign HADDR    = HSEL ? M_HADDR[32'(g)*ADDR_W +: ADDR_W] : '0;
  assign HWRITE   = HSEL ? M_HWRITE[g] : 1'b0;
  assign HWDATA   = M_HWDATA[32'(d)*DATA_W +: DATA_W];
  assign HREADY   = HREADYOUT;
  assign M_HREADY = HREADYOUT;
  assign M_HRDATA = HRDATA;
  assign M_HGRANT = grant;
  assign HMASTER  = g;

  // Data-phase valid and lock inputs are kept for interface stability only.
  assign unused_ok = ^{M_HLOCK, v};

endmodule

// File: tb/tb_ahb_apb_master_arbiter.sv
// Directed bench for ahb_apb_master_arbiter with a queue of expected values.
module tb_ahb_apb_master_arbiter;
  localparam int unsigned NM = 4;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  logic           HCLK = 1'b0;
  logic           RESET;
  logic [NM-1:0]  M_HBUSREQ, M_HLOCK, M_HSEL, M_HWRITE;
  logic [NM*AW-1:0] M_HADDR;
  logic [NM*DW-1:0] M_HWDATA;
  logic [NM-1:0]  M_HGRANT;
  logic           M_HREADY;
  logic [DW-1:0]  M_HRDATA;
  logic [1:0]     HMASTER;
  logic           HSEL, HWRITE, HREADY, HREADYOUT;
  logic [AW-1:0]  HADDR;
  logic [DW-1:0]  HWDATA, HRDATA;

  always #5 HCLK = ~HCLK;

  ahb_apb_master_arbiter dut (
    .HCLK(HCLK), .RESET(RESET), .M_HBUSREQ(M_HBUSREQ), .M_HLOCK(M_HLOCK),
    .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HWRITE(M_HWRITE), .M_HWDATA(M_HWDATA),
    .M_HGRANT(M_HGRANT), .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .HMASTER(HMASTER),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s(%s) observed=%0h expected=%0h", tag, e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  initial begin
    RESET = 1'b1; HREADYOUT = 1'b1; HRDATA = 32'hDEAD_BEEF;
    M_HBUSREQ = '0; M_HLOCK = '0; M_HSEL = 4'b0100; M_HWRITE = 4'b0101;
    for (int i = 0; i < int'(NM); i++) begin
      M_HADDR[i*AW +: AW]  = AW'(32'h20 + 32'(i));
      M_HWDATA[i*DW +: DW] = DW'(32'h1111_1111 * 32'(i + 1));
    end

    // Reset: everything quiet, write data from master 0
    expect_v("rst_grant", 0); expect_v("rst_hmaster", 0); expect_v("rst_hsel", 0);
    expect_v("rst_haddr", 0); expect_v("rst_hwrite", 0); expect_v("rst_hwdata", 64'h1111_1111);
    step(2);
    check("rst_grant", M_HGRANT); check("rst_hmaster", HMASTER); check("rst_hsel", HSEL);
    check("rst_haddr", HADDR); check("rst_hwrite", HWRITE); check("rst_hwdata", HWDATA);

    // Single request granted after one edge
    RESET = 1'b0; M_HSEL = '0; M_HBUSREQ = 4'b0100;
    expect_v("req_grant", 4'b0100); expect_v("req_hmaster", 2);
    step(1);
    check("req_grant", M_HGRANT); check("req_hmaster", HMASTER);

    // Last transfer accepted while request drops: back to idle
    M_HBUSREQ = '0; M_HSEL = 4'b0100;
    expect_v("idle_grant", 0); expect_v("idle_hsel", 0);
    step(1);
    check("idle_grant", M_HGRANT); check("idle_hsel", HSEL);

    // Round robin between masters 0 and 1 (pointer now at 3)
    M_HBUSREQ = 4'b0011; M_HSEL = 4'b0011;
    expect_v("rr_g0", 4'b0001); step(1); check("rr_g0", M_HGRANT);
    expect_v("rr_g0_hold", 4'b0001); step(3); check("rr_g0_hold", M_HGRANT);
    expect_v("rr_g1", 4'b0010); step(1); check("rr_g1", M_HGRANT);
    expect_v("rr_g1_hold", 4'b0010); step(3); check("rr_g1_hold", M_HGRANT);
    expect_v("rr_g0_again", 4'b0001); step(1); check("rr_g0_again", M_HGRANT);

    // Wait states across the quota-expiry edge
    step(3);
    HREADYOUT = 1'b0;
    expect_v("ws_grant", 4'b0001); expect_v("ws_hmaster", 0);
    expect_v("ws_hready", 0); expect_v("ws_m_hready", 0); expect_v("ws_m_hrdata", 64'hDEAD_BEEF);
    step(3);
    check("ws_grant", M_HGRANT); check("ws_hmaster", HMASTER);
    check("ws_hready", HREADY); check("ws_m_hready", M_HREADY); check("ws_m_hrdata", M_HRDATA);
    HREADYOUT = 1'b1;
    expect_v("ws_handover", 4'b0010); step(1); check("ws_handover", M_HGRANT);

    // Write-data alignment across a handover from master 0 to master 2
    M_HBUSREQ = 4'b0001; M_HSEL = 4'b0001;
    expect_v("wd_g0", 4'b0001); step(1); check("wd_g0", M_HGRANT);
    M_HBUSREQ = 4'b0101; M_HSEL = 4'b0101;
    step(3);
    M_HWDATA[0 +: DW] = 32'hA5A5_A5A5;
    expect_v("wd_grant", 4'b0100); expect_v("wd_hwdata", 64'hA5A5_A5A5);
    expect_v("wd_haddr", 64'h22); expect_v("wd_hwrite", 1);
    step(1);
    check("wd_grant", M_HGRANT); check("wd_hwdata", HWDATA);
    check("wd_haddr", HADDR); check("wd_hwrite", HWRITE);

    // Locked sequence by master 1 with master 3 requesting
    M_HBUSREQ = 4'b0010; M_HSEL = 4'b0010; M_HLOCK = 4'b0010;
    expect_v("lk_g1", 4'b0010); step(1); check("lk_g1", M_HGRANT);
    M_HBUSREQ = 4'b1010; M_HSEL = 4'b1010;
    step(3);
`ifdef ARB_LOCK_EN
    expect_v("lk_hold", 4'b0010); step(5); check("lk_hold", M_HGRANT);
    M_HBUSREQ = 4'b1000;
    expect_v("lk_release", 4'b1000); expect_v("lk_hmaster", 3);
    step(1);
    check("lk_release", M_HGRANT); check("lk_hmaster", HMASTER);
`else
    expect_v("lk_quota", 4'b1000); expect_v("lk_hmaster", 3);
    step(1);
    check("lk_quota", M_HGRANT); check("lk_hmaster", HMASTER);
`endif

    // Sole requester keeps the grant past the quota
    M_HBUSREQ = 4'b0100; M_HSEL = 4'b0100; M_HLOCK = '0;
    expect_v("sole_g2", 4'b0100); step(1); check("sole_g2", M_HGRANT);
    expect_v("sole_hold", 4'b0100); expect_v("sole_hmaster", 2); expect_v("sole_hsel", 1);
    step(6);
    check("sole_hold", M_HGRANT); check("sole_hmaster", HMASTER); check("sole_hsel", HSEL);

    // Reset during a wait state
    HREADYOUT = 1'b0; RESET = 1'b1;
    expect_v("mid_rst_grant", 0); expect_v("mid_rst_hmaster", 0); expect_v("mid_rst_hsel", 0);
    step(1);
    check("mid_rst_grant", M_HGRANT); check("mid_rst_hmaster", HMASTER); check("mid_rst_hsel", HSEL);
    RESET = 1'b0; HREADYOUT = 1'b1; M_HBUSREQ = '0;
    expect_v("post_grant", 0); expect_v("post_hsel", 0);
    step(1);
    check("post_grant", M_HGRANT); check("post_hsel", HSEL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
